// File: rtl/scan_decoder_if.sv
// rtl/scan_decoder_if.sv - enable/mode/select inputs and decoded select-line outputs of scan_decoder
interface scan_decoder_if #(
  parameter int SEL_W = 3
);
  localparam int OUT_N = 2**SEL_W;

  logic [1:0]       iEna;
  logic             iMode;
  logic [SEL_W-1:0] iData;
  logic [OUT_N-1:0] oData;
  logic [SEL_W-1:0] oSel;
  logic             oWrap;

  modport master (output iEna, iMode, iData, input oData, oSel, oWrap);
  modport slave  (input iEna, iMode, iData, output oData, oSel, oWrap);
endinterface

// File: rtl/scan_decoder.sv
// rtl/scan_decoder.sv - registered N-to-2^N active-low decoder with direct and prescaled scan modes
// Optional blanking at the start of every scan channel is built when SCAN_BLANK_EN is defined.
module scan_decoder #(
  parameter int SEL_W     = 3,
  parameter int LAST      = 2**SEL_W-1,
  parameter int TICK_DIV  = 100000,
  parameter int BLANK_CYC = 2
) (
  input  logic          iClk,
  input  logic          iRst,
  scan_decoder_if.slave bus
);
  localparam int OUT_N = 2**SEL_W;
  localparam int PRE_W = $clog2(TICK_DIV);

  typedef enum logic [1:0] {IDLE, DIRECT, SCAN} state_t;

  generate
    if (TICK_DIV < 2 || BLANK_CYC >= TICK_DIV || LAST < 0 || LAST >= OUT_N) begin : g_bad_params
      $error("scan_decoder: illegal parameter set");
    end
  endgenerate

  state_t           state_q, state_d;
  logic [SEL_W-1:0] idx_q, idx_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [OUT_N-1:0] data_q, data_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             wrap_q, wrap_d;

  logic enabled;
  logic terminal;
  logic at_last;

  assign enabled  = (bus.iEna == 2'b10);
  assign terminal = (pre_q == PRE_W'(TICK_DIV-1));
  assign at_last  = (idx_q == SEL_W'(LAST));

  always_ff @(posedge iClk or posedge iRst) begin
    if (iRst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      pre_q   <= '0;
      data_q  <= '1;
      sel_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      pre_q   <= pre_d;
      data_q  <= data_d;
      sel_q   <= sel_d;
      wrap_q  <= wrap_d;
    end
  end

  always_comb begin
    state_d = IDLE;
    if (enabled) begin
      state_d = bus.iMode ? SCAN : DIRECT;
    end
  end

  // Actions follow the state being entered, so a mode change on a terminal count suppresses the step.
  always_comb begin
    idx_d  = idx_q;
    pre_d  = pre_q;
    data_d = '1;
    sel_d  = '0;
    wrap_d = 1'b0;
    case (state_d)
      DIRECT: begin
        data_d = ~(OUT_N'(1) << bus.iData);
        sel_d  = bus.iData;
      end
      SCAN: begin
        if (state_q == DIRECT) begin
          idx_d = '0;
          pre_d = '0;
        end else if (terminal) begin
          pre_d  = '0;
          idx_d  = at_last ? '0 : idx_q + SEL_W'(1);
          wrap_d = at_last;
        end else begin
          pre_d = pre_q + PRE_W'(1);
        end
        data_d = ~(OUT_N'(1) << idx_d);
        sel_d  = idx_d;
`ifdef SCAN_BLANK_EN
        if (pre_d < PRE_W'(BLANK_CYC)) begin
          data_d = '1;
        end
`else
`endif
      end
      default: ;
    endcase
  end

  assign bus.oData = data_q;
  assign bus.oSel  = sel_q;
  assign bus.oWrap = wrap_q;
endmodule
